// File: rtl/openofdm_corr_pkg.sv
// Shared widths and packed-sample I/Q helpers for the delay-and-correlate stage.
package openofdm_corr_pkg;

    localparam int unsigned MAX_SW = 32;
    localparam int unsigned PACK_W = 2 * MAX_SW;

    function automatic int unsigned prod_w(input int unsigned sample_width);
        return 2 * sample_width + 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned sample_width,
                                          input int unsigned window_shift);
        return prod_w(sample_width) + window_shift;
    endfunction

    // Samples are zero-padded into PACK_W bits; result is sign-extended to MAX_SW.
    function automatic logic signed [MAX_SW-1:0] sample_i(input logic [PACK_W-1:0] s,
                                                           input int unsigned sw);
        logic signed [PACK_W-1:0] t;
        t = s << (PACK_W - 2 * sw);
        t = t >>> (PACK_W - sw);
        return MAX_SW'(t);
    endfunction

    function automatic logic signed [MAX_SW-1:0] sample_q(input logic [PACK_W-1:0] s,
                                                           input int unsigned sw);
        logic signed [PACK_W-1:0] t;
        t = s << (PACK_W - sw);
        t = t >>> (PACK_W - sw);
        return MAX_SW'(t);
    endfunction

endpackage

// File: rtl/moving_sum.sv
// Moving sum over the last 2^SHIFT valid inputs, with circular history and fill flag.
module moving_sum #(
    parameter int unsigned DATA_W = 33,
    parameter int unsigned SHIFT  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           valid,
    input  logic signed [DATA_W-1:0]       data_in,
    output logic signed [DATA_W+SHIFT-1:0] acc,
    output logic                           full
);

    localparam int unsigned ACC_W = DATA_W + SHIFT;
    localparam int unsigned DEPTH = 1 << SHIFT;

    logic signed [DATA_W-1:0] hist [DEPTH];
    logic        [SHIFT-1:0]  ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist <= '{default: '0};
            ptr  <= '0;
            acc  <= '0;
            full <= 1'b0;
        end else if (valid) begin
            acc       <= acc + ACC_W'(data_in) - ACC_W'(hist[ptr]);
            hist[ptr] <= data_in;
            ptr       <= ptr + 1'b1;
            if (ptr == '1)
                full <= 1'b1;
        end
    end

endmodule

// File: rtl/delay_corr.sv
// Delay-and-correlate: windowed x[n]*conj(x[n-D]) and, with DELAY_CORR_ENERGY_EN
// defined, windowed |x[n]|^2 on the energy port (tied to 0 otherwise).
module delay_corr
    import openofdm_corr_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned WINDOW_SHIFT = 4
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   enable,
    input  logic        [2*SAMPLE_WIDTH-1:0]                       sample_in,
    input  logic        [2*SAMPLE_WIDTH-1:0]                       sample_delayed,
    input  logic                                                   input_strobe,
    output logic signed [acc_w(SAMPLE_WIDTH, WINDOW_SHIFT)-1:0]    corr_i,
    output logic signed [acc_w(SAMPLE_WIDTH, WINDOW_SHIFT)-1:0]    corr_q,
    output logic signed [acc_w(SAMPLE_WIDTH, WINDOW_SHIFT)-1:0]    energy,
    output logic                                                   window_full,
    output logic                                                   output_strobe
);

    localparam int unsigned PROD_W = prod_w(SAMPLE_WIDTH);

    logic signed [PROD_W-1:0] x_i, x_q, d_i, d_q;
    logic signed [PROD_W-1:0] re_q, im_q;
    logic                     v1, v2;
    logic                     sum_valid;
    logic                     full_re, full_im;

    // Operands are widened to PROD_W first so the products cannot wrap.
    always_comb begin
        x_i = PROD_W'(sample_i(PACK_W'(sample_in), SAMPLE_WIDTH));
        x_q = PROD_W'(sample_q(PACK_W'(sample_in), SAMPLE_WIDTH));
        d_i = PROD_W'(sample_i(PACK_W'(sample_delayed), SAMPLE_WIDTH));
        d_q = PROD_W'(sample_q(PACK_W'(sample_delayed), SAMPLE_WIDTH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            re_q <= '0;
            im_q <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
        end else if (enable) begin
            v1 <= input_strobe;
            v2 <= v1;
            if (input_strobe) begin
                re_q <= x_i * d_i + x_q * d_q;
                im_q <= x_q * d_i - x_i * d_q;
            end
        end
    end

    assign sum_valid     = v1 & enable;
    assign output_strobe = v2 & enable;

    moving_sum #(.DATA_W(PROD_W), .SHIFT(WINDOW_SHIFT)) u_sum_re (
        .clock   (clock),
        .reset   (reset),
        .valid   (sum_valid),
        .data_in (re_q),
        .acc     (corr_i),
        .full    (full_re)
    );

    moving_sum #(.DATA_W(PROD_W), .SHIFT(WINDOW_SHIFT)) u_sum_im (
        .clock   (clock),
        .reset   (reset),
        .valid   (sum_valid),
        .data_in (im_q),
        .acc     (corr_q),
        .full    (full_im)
    );

    assign window_full = full_re;

`ifdef DELAY_CORR_ENERGY_EN
    logic signed [PROD_W-1:0] pw_q;
    logic                     full_pw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pw_q <= '0;
        else if (enable && input_strobe)
            pw_q <= x_i * x_i + x_q * x_q;
    end

    moving_sum #(.DATA_W(PROD_W), .SHIFT(WINDOW_SHIFT)) u_sum_pw (
        .clock   (clock),
        .reset   (reset),
        .valid   (sum_valid),
        .data_in (pw_q),
        .acc     (energy),
        .full    (full_pw)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            assert (full_pw == full_re);
    end
`else
    assign energy = '0;
`endif

    // All channels share one valid, so their fill flags must agree.
    always_ff @(posedge clock) begin
        if (!reset)
            assert (full_im == full_re);
    end

endmodule

// File: tb/tb_delay_corr.sv
// Self-checking bench for delay_corr: vector table, corner sequences and random traffic
// against a windowed-sum reference model.
`timescale 1ns/1ps
module tb_delay_corr;

    localparam int SW    = 16;
    localparam int WS    = 4;
    localparam int ACC_W = 2 * SW + 1 + WS;
    localparam int DEPTH = 1 << WS;
`ifdef DELAY_CORR_ENERGY_EN
    localparam bit ENERGY_ON = 1'b1;
`else
    localparam bit ENERGY_ON = 1'b0;
`endif

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b0;
    logic                    input_strobe = 1'b0;
    logic [2*SW-1:0]         sample_in = '0;
    logic [2*SW-1:0]         sample_delayed = '0;
    logic signed [ACC_W-1:0] corr_i, corr_q, energy;
    logic                    window_full, output_strobe;

    delay_corr #(.SAMPLE_WIDTH(SW), .WINDOW_SHIFT(WS)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_delayed (sample_delayed),
        .input_strobe   (input_strobe),
        .corr_i         (corr_i),
        .corr_q         (corr_q),
        .energy         (energy),
        .window_full    (window_full),
        .output_strobe  (output_strobe)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: products of the last DEPTH accepted strobes, summed on demand.
    typedef struct {
        longint i;
        longint q;
        longint e;
        bit     full;
        int     c0;
    } exp_t;

    exp_t   sb[$];
    longint win_re[$];
    longint win_im[$];
    longint win_pw[$];
    int     n_acc = 0;
    bit     lat_chk = 1'b1;

    task automatic model_reset();
        win_re.delete();
        win_im.delete();
        win_pw.delete();
        sb.delete();
        n_acc = 0;
    endtask

    task automatic model_push(input int xi, input int xq, input int di, input int dq, input int c0);
        exp_t e;
        win_re.push_back(longint'(xi) * di + longint'(xq) * dq);
        win_im.push_back(longint'(xq) * di - longint'(xi) * dq);
        win_pw.push_back(longint'(xi) * xi + longint'(xq) * xq);
        if (win_re.size() > DEPTH) begin
            win_re.delete(0);
            win_im.delete(0);
            win_pw.delete(0);
        end
        n_acc++;
        e.i = 0;
        e.q = 0;
        e.e = 0;
        foreach (win_re[k]) begin
            e.i += win_re[k];
            e.q += win_im[k];
            e.e += win_pw[k];
        end
        if (!ENERGY_ON) e.e = 0;
        e.full = (n_acc >= DEPTH);
        e.c0   = c0;
        sb.push_back(e);
    endtask

    task automatic drive(input bit stb, input bit en, input int xi, input int xq,
                         input int di, input int dq);
        logic [31:0] a, b, c, d;
        a = xi; b = xq; c = di; d = dq;
        sample_in      = {a[15:0], b[15:0]};
        sample_delayed = {c[15:0], d[15:0]};
        input_strobe   = stb;
        enable         = en;
        if (stb && en) model_push(xi, xq, di, dq, edge_cnt);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        input_strobe = 1'b0;
        enable       = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clock);
            check("rst_corr_i", corr_i, 0);
            check("rst_corr_q", corr_q, 0);
            check("rst_energy", energy, 0);
            check("rst_window_full", window_full, 0);
            check("rst_output_strobe", output_strobe, 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    exp_t ce;
    always @(negedge clock) begin
        if (!reset) begin
            if (!enable) check("strobe_while_disabled", output_strobe, 0);
            if (output_strobe) begin
                check("result_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ce = sb.pop_front();
                    check("corr_i", corr_i, ce.i);
                    check("corr_q", corr_q, ce.q);
                    check("energy", energy, ce.e);
                    check("window_full", window_full, ce.full);
                    if (lat_chk) check("latency", edge_cnt - ce.c0, 2);
                end
            end
        end
    end

    typedef struct {
        int     xi, xq, di, dq, n;
        longint ei, eq, ee;
        bit     full;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{xi: 100, xq: 0, di: 100, dq: 0, n: 20,
                  ei: 160000, eq: 0, ee: 160000, full: 1'b1};
        vt[1] = '{xi: 0, xq: 100, di: 100, dq: 0, n: 16,
                  ei: 0, eq: 160000, ee: 160000, full: 1'b1};
        vt[2] = '{xi: -32768, xq: -32768, di: -32768, dq: -32768, n: 16,
                  ei: 64'sd34359738368, eq: 0, ee: 64'sd34359738368, full: 1'b1};
        vt[3] = '{xi: 3, xq: -4, di: -5, dq: 2, n: 5,
                  ei: -115, eq: 70, ee: 125, full: 1'b0};
        vt[4] = '{xi: 32767, xq: -32768, di: -32768, dq: 32767, n: 16,
                  ei: -64'sd34358689792, eq: 1048560, ee: 64'sd34358689808, full: 1'b1};

        #1 reset = 1'b1;
        do_reset();

        for (int v = 0; v < 5; v++) begin
            do_reset();
            repeat (vt[v].n) drive(1'b1, 1'b1, vt[v].xi, vt[v].xq, vt[v].di, vt[v].dq);
            idle(4);
            check("tbl_corr_i", corr_i, vt[v].ei);
            check("tbl_corr_q", corr_q, vt[v].eq);
            check("tbl_energy", energy, ENERGY_ON ? vt[v].ee : 64'sd0);
            check("tbl_window_full", window_full, vt[v].full);
        end

        // Strobe every third cycle: same sums, same 2-cycle latency.
        do_reset();
        repeat (20) begin
            drive(1'b1, 1'b1, 100, 0, 100, 0);
            idle(2);
        end
        idle(3);
        check("gap_corr_i", corr_i, 160000);
        check("gap_window_full", window_full, 1);

        // Reset mid-window, then a fresh ramp.
        do_reset();
        repeat (10) drive(1'b1, 1'b1, 100, 0, 100, 0);
        idle(3);
        check("pre_rst_corr_i", corr_i, 100000);
        do_reset();
        drive(1'b1, 1'b1, 100, 0, 100, 0);
        idle(3);
        check("restart_corr_i", corr_i, 10000);
        check("restart_window_full", window_full, 0);

        // Enable dropped for 5 cycles with strobes in flight.
        do_reset();
        lat_chk = 1'b0;
        repeat (5) drive(1'b1, 1'b1, 100, 0, 100, 0);
        repeat (5) drive(1'b0, 1'b0, 0, 0, 0, 0);
        repeat (3) drive(1'b1, 1'b1, 100, 0, 100, 0);
        idle(4);
        check("hold_corr_i", corr_i, 80000);
        check("hold_corr_q", corr_q, 0);

        // Random traffic with random enable gaps.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [15:0] r0, r1, r2, r3;
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            r3 = 16'($urandom);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0,
                  int'($signed(r0)), int'($signed(r1)), int'($signed(r2)), int'($signed(r3)));
        end
        idle(4);
        lat_chk = 1'b1;

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
